// File: rtl/serdesphy_rx_ctrl_pkg.sv
// serdesphy_rx_ctrl_pkg: shared state encoding and defaults for the RX front-end sequencer
package serdesphy_rx_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } rx_state_e;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_DET_CYCLES = 32;
    localparam int DEF_LOS_CYCLES = 64;
    localparam int DEF_ACQ_TIMEOUT = 1024;
    localparam logic [7:0] LOS_COUNT_MAX = 8'd255;
endpackage

// File: rtl/serdesphy_rx_run_counter.sv
// serdesphy_rx_run_counter: counts consecutive din=1 cycles; term flags the cycle the run would reach N
module serdesphy_rx_run_counter #(
    parameter int N = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cnt_en,
    input  logic din,
    output logic term
);
    localparam int W = $clog2(N + 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        term = cnt_en && din && (cnt_q == W'(N - 1));
        cnt_d = clr ? '0 : !cnt_en ? cnt_q : din ? cnt_q + 1'b1 : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/serdesphy_rx_frontend_ctrl.sv
// serdesphy_rx_frontend_ctrl: RX receiver power-up sequencer with signal-detect qualification and LOS monitoring
module serdesphy_rx_frontend_ctrl
    import serdesphy_rx_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int DET_CYCLES = DEF_DET_CYCLES,
    parameter int LOS_CYCLES = DEF_LOS_CYCLES,
    parameter int ACQ_TIMEOUT = DEF_ACQ_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       lpbk_req,
    input  logic       signal_detected,
    output logic       rx_enable,
    output logic       iso_en,
    output logic       lpbk_en,
    output logic       rx_ready,
    output logic       los_event,
    output logic       fault,
    output logic [7:0] los_count,
    output logic [2:0] state
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(ACQ_TIMEOUT + 1);
    rx_state_e state_q, state_d;
    logic [SW-1:0] set_q, set_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0] los_count_q, los_count_d;
    logic rx_enable_q, rx_enable_d, iso_en_q, iso_en_d, lpbk_en_q, lpbk_en_d;
    logic rx_ready_q, rx_ready_d, los_event_q, los_event_d, fault_q, fault_d;
    logic lpbk_diff, restart, load, det_term, los_term;
    serdesphy_rx_run_counter #(.N(DET_CYCLES)) u_det_cnt (
        .clk(clk), .rst(rst), .clr(state_d != ST_ACQUIRE), .cnt_en(state_q == ST_ACQUIRE),
        .din(signal_detected), .term(det_term)
    );
    serdesphy_rx_run_counter #(.N(LOS_CYCLES)) u_los_cnt (
        .clk(clk), .rst(rst), .clr(state_d != ST_LOCKED), .cnt_en(state_q == ST_LOCKED),
        .din(~signal_detected), .term(los_term)
    );
    always_comb begin
        lpbk_diff = lpbk_req != lpbk_en_q;
        restart = en && lpbk_diff && (state_q inside {ST_SETTLE, ST_ACQUIRE, ST_LOCKED});
        load = restart || (en && state_q == ST_OFF);
        state_d = ST_OFF;
        if (en) begin
            case (state_q)
                ST_OFF:     state_d = ST_SETTLE;
                ST_SETTLE:  state_d = lpbk_diff ? ST_SETTLE
                                    : (set_q == SW'(SETTLE_CYCLES - 1)) ? ST_ACQUIRE : ST_SETTLE;
                // detection outranks a timeout landing on the same cycle
                ST_ACQUIRE: state_d = lpbk_diff ? ST_SETTLE : det_term ? ST_LOCKED
                                    : (tmo_q == TW'(ACQ_TIMEOUT - 1)) ? ST_FAULT : ST_ACQUIRE;
                ST_LOCKED:  state_d = lpbk_diff ? ST_SETTLE : los_term ? ST_ACQUIRE : ST_LOCKED;
                ST_FAULT:   state_d = ST_FAULT;
                default:    state_d = ST_OFF;
            endcase
        end
        los_event_d = en && !lpbk_diff && los_term;
        set_d = (state_q == ST_SETTLE && state_d == ST_SETTLE && !restart) ? set_q + 1'b1 : '0;
        tmo_d = (state_q == ST_ACQUIRE && state_d == ST_ACQUIRE) ? tmo_q + 1'b1 : '0;
        lpbk_en_d = load ? lpbk_req : lpbk_en_q;
        los_count_d = (los_event_d && los_count_q != LOS_COUNT_MAX) ? los_count_q + 1'b1 : los_count_q;
        rx_enable_d = state_d inside {ST_SETTLE, ST_ACQUIRE, ST_LOCKED};
        iso_en_d = !rx_enable_d;
        rx_ready_d = state_d == ST_LOCKED;
        fault_d = state_d == ST_FAULT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            set_q <= '0;
            tmo_q <= '0;
            los_count_q <= '0;
            rx_enable_q <= 1'b0;
            iso_en_q <= 1'b1;
            lpbk_en_q <= 1'b0;
            rx_ready_q <= 1'b0;
            los_event_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q <= set_d;
            tmo_q <= tmo_d;
            los_count_q <= los_count_d;
            rx_enable_q <= rx_enable_d;
            iso_en_q <= iso_en_d;
            lpbk_en_q <= lpbk_en_d;
            rx_ready_q <= rx_ready_d;
            los_event_q <= los_event_d;
            fault_q <= fault_d;
        end
    end
    assign rx_enable = rx_enable_q;
    assign iso_en = iso_en_q;
    assign lpbk_en = lpbk_en_q;
    assign rx_ready = rx_ready_q;
    assign los_event = los_event_q;
    assign fault = fault_q;
    assign los_count = los_count_q;
    assign state = state_q;
endmodule

// File: tb/tb_serdesphy_rx_frontend_ctrl.sv
// tb_serdesphy_rx_frontend_ctrl: directed and random stimulus scored against a behavioural model
module tb_serdesphy_rx_frontend_ctrl;
    localparam int S = 16, D = 32, L = 64, T = 1024;
    typedef struct packed {
        logic [2:0] st;
        logic rxe, iso, lpe, rdy, ev, flt;
        logic [7:0] cnt;
    } obs_t;
    logic clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, lpbk_req = 1'b0, signal_detected = 1'b0;
    logic rx_enable, iso_en, lpbk_en, rx_ready, los_event, fault;
    logic [7:0] los_count;
    logic [2:0] state;
    obs_t exp_q[$];
    obs_t e_o, g_o;
    int tests = 0, fails = 0, cyc = 0;
    int m_st = 0, m_set = 0, m_det = 0, m_acq = 0, m_zero = 0, m_los = 0;
    bit m_lp = 0, m_ev = 0;
    serdesphy_rx_frontend_ctrl #(
        .SETTLE_CYCLES(S), .DET_CYCLES(D), .LOS_CYCLES(L), .ACQ_TIMEOUT(T)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .lpbk_req(lpbk_req), .signal_detected(signal_detected),
        .rx_enable(rx_enable), .iso_en(iso_en), .lpbk_en(lpbk_en), .rx_ready(rx_ready),
        .los_event(los_event), .fault(fault), .los_count(los_count), .state(state)
    );
    initial forever #5 clk = ~clk;
    task automatic model(input bit r, input bit e, input bit l, input bit s);
        m_ev = 0;
        if (r) begin
            m_st = 0; m_lp = 0; m_los = 0;
        end else if (!e) m_st = 0;
        else if (m_st >= 1 && m_st <= 3 && l != m_lp) begin
            m_st = 1; m_lp = l; m_set = 0;
        end else begin
            case (m_st)
                0: begin m_st = 1; m_lp = l; m_set = 0; end
                1: begin
                    m_set++;
                    if (m_set == S) begin m_st = 2; m_det = 0; m_acq = 0; end
                end
                2: begin
                    m_det = s ? m_det + 1 : 0;
                    m_acq++;
                    if (m_det == D) begin m_st = 3; m_zero = 0; end
                    else if (m_acq == T) m_st = 4;
                end
                3: begin
                    m_zero = s ? 0 : m_zero + 1;
                    if (m_zero == L) begin
                        m_st = 2; m_ev = 1; m_det = 0; m_acq = 0;
                        m_los = (m_los < 255) ? m_los + 1 : 255;
                    end
                end
                default: ;
            endcase
        end
        exp_q.push_back('{st: 3'(m_st), rxe: (m_st >= 1 && m_st <= 3), iso: !(m_st >= 1 && m_st <= 3),
                          lpe: m_lp, rdy: m_st == 3, ev: m_ev, flt: m_st == 4, cnt: 8'(m_los)});
    endtask
    task automatic step(input bit r, input bit e, input bit l, input bit s);
        @(negedge clk);
        rst = r; en = e; lpbk_req = l; signal_detected = s;
        model(r, e, l, s);
        @(posedge clk);
    endtask
    task automatic los_cycle(input bit l);
        repeat (40) step(0, 1, l, 1);
        repeat (L) step(0, 1, l, 0);
    endtask
    initial begin
        #2_000_000;
        fails++;
        $display("FAIL timeout: stimulus did not complete, cyc=%0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e_o = exp_q.pop_front();
            g_o = {state, rx_enable, iso_en, lpbk_en, rx_ready, los_event, fault, los_count};
            tests++;
            if (g_o !== e_o) begin
                fails++;
                $display("FAIL outputs cyc=%0d got st=%0d rxe=%b iso=%b lpe=%b rdy=%b ev=%b flt=%b cnt=%0d want st=%0d rxe=%b iso=%b lpe=%b rdy=%b ev=%b flt=%b cnt=%0d",
                         cyc, g_o.st, g_o.rxe, g_o.iso, g_o.lpe, g_o.rdy, g_o.ev, g_o.flt, g_o.cnt,
                         e_o.st, e_o.rxe, e_o.iso, e_o.lpe, e_o.rdy, e_o.ev, e_o.flt, e_o.cnt);
            end
        end
    end
    initial begin
        bit e, l, s, r;
        repeat (3) step(1, 0, 0, 0);
        #2;
        tests++;
        if ({state, rx_enable, iso_en, lpbk_en, rx_ready, los_event, fault, los_count} !==
            {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL reset state st=%0d rxe=%b iso=%b lpe=%b rdy=%b ev=%b flt=%b cnt=%0d",
                     state, rx_enable, iso_en, lpbk_en, rx_ready, los_event, fault, los_count);
        end
        repeat (7) step(0, 0, 0, 1);
        repeat (60) step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        repeat (20) step(0, 1, 1, 0);
        repeat (31) step(0, 1, 1, 1);
        step(0, 1, 1, 0);
        repeat (37) step(0, 1, 1, 1);
        repeat (L - 1) step(0, 1, 1, 0);
        step(0, 1, 1, 1);
        repeat (L) step(0, 1, 1, 0);
        repeat (T + 80) step(0, 1, 1, 0);
        repeat (5) step(0, 0, 1, 0);
        repeat (50) step(0, 1, 0, 1);
        repeat (2) los_cycle(0);
        step(1, 1, 0, 1);
        repeat (50) step(0, 1, 0, 1);
        repeat (260) los_cycle(0);
        repeat (10) step(0, 1, 0, 1);
        e = 1; l = 0; s = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) s = ~s;
            if ($urandom_range(499) == 0) e = ~e;
            if (!e && $urandom_range(9) == 0) e = 1;
            if ($urandom_range(699) == 0) l = ~l;
            r = ($urandom_range(1999) == 0);
            step(r, e, l, s);
        end
        repeat (2) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
